// File: rtl/uart_boot_loader.sv
// UART boot loader: takes command/address/count/data words from a 32-bit UART
// receiver, writes the data words to memory and holds the CPU in reset until told to run.
module uart_boot_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0]  CMD_LOAD       = 8'h4C,
  parameter logic [7:0]  CMD_RUN        = 8'h52
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_data,
  input  logic        rx_done,
  output logic        rx_one_byte,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        error,
  output logic [31:0] checksum,
  output logic [2:0]  dbg_state
);

  // Handshake: rx_done is a one-cycle valid pulse with rx_data qualified in the
  // same cycle; there is no ready, so a pulse arriving in WRITE is dropped.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    GET_COUNT = 3'd2,
    GET_DATA  = 3'd3,
    WRITE     = 3'd4
  } state_e;

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        rx_one_byte_q, rx_one_byte_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic [31:0] checksum_q, checksum_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [15:0] remain_q, remain_d;

  logic        timer_run;
  logic [31:0] timer_inc;
  logic        timeout;
  logic        is_load;
  logic        is_run;
  logic        last_word;

  assign timer_run = (state_q == GET_ADDR) || (state_q == GET_COUNT) ||
                     (state_q == GET_DATA);
  assign timer_inc = timer_q + 32'd1;
  // An rx_done in the expiry cycle wins over the timeout.
  assign timeout   = timer_run && !rx_done && (timer_inc >= TIMEOUT_LIMIT);
  assign is_load   = rx_done && (rx_data[7:0] == CMD_LOAD);
  assign is_run    = rx_done && (rx_data[7:0] == CMD_RUN);
  assign last_word = (remain_q <= 16'd1);

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rx_one_byte_q <= 1'b1;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      cpu_reset_q   <= 1'b1;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      checksum_q    <= 32'd0;
      timer_q       <= 32'd0;
      wr_addr_q     <= 32'd0;
      remain_q      <= 16'd0;
    end else begin
      state_q       <= state_d;
      rx_one_byte_q <= rx_one_byte_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_reset_q   <= cpu_reset_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      checksum_q    <= checksum_d;
      timer_q       <= timer_d;
      wr_addr_q     <= wr_addr_d;
      remain_q      <= remain_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (is_load) state_d = GET_ADDR;
      end
      GET_ADDR: begin
        if (rx_done)      state_d = GET_COUNT;
        else if (timeout) state_d = IDLE;
      end
      GET_COUNT: begin
        if (rx_done)      state_d = (rx_data[15:0] == 16'd0) ? IDLE : GET_DATA;
        else if (timeout) state_d = IDLE;
      end
      GET_DATA: begin
        if (rx_done)      state_d = WRITE;
        else if (timeout) state_d = IDLE;
      end
      WRITE: begin
        state_d = last_word ? IDLE : GET_DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; outputs are registered so they change
  // on the same edge as the state.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    error_d     = error_q;
    checksum_d  = checksum_q;
    wr_addr_d   = wr_addr_q;
    remain_d    = remain_q;
    timer_d     = (timer_run && !rx_done) ? timer_inc : 32'd0;

    case (state_q)
      IDLE: begin
        if (is_load) begin
          busy_d      = 1'b1;
          error_d     = 1'b0;
          checksum_d  = 32'd0;
          cpu_reset_d = 1'b1;
        end else if (is_run) begin
          cpu_reset_d = 1'b0;
          error_d     = 1'b0;
        end else if (rx_done) begin
          error_d = 1'b1;
        end
      end
      GET_ADDR: begin
        if (rx_done) wr_addr_d = rx_data;
      end
      GET_COUNT: begin
        if (rx_done) begin
          remain_d = rx_data[15:0];
          if (rx_data[15:0] == 16'd0) busy_d = 1'b0;
        end
      end
      GET_DATA: begin
        if (rx_done) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_q;
          mem_wdata_d = rx_data;
        end
      end
      WRITE: begin
        checksum_d = checksum_q ^ mem_wdata_q;
        wr_addr_d  = wr_addr_q + 32'd4;
        remain_d   = remain_q - 16'd1;
        if (last_word) busy_d = 1'b0;
      end
      default: ;
    endcase

    if (timeout) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  assign rx_one_byte_d = (state_d == IDLE);

  assign rx_one_byte = rx_one_byte_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign busy        = busy_q;
  assign error       = error_q;
  assign checksum    = checksum_q;
  assign dbg_state   = state_q;

endmodule
